// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Optional feature macro: FETCH_ADEL_EN (misaligned-fetch detection, adds adel field).
package fetch_stage_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'hBFC0_0000;
  localparam logic [XLEN-1:0] NOP_INST_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP      = 32'd4;

  // IF/ID pipeline register payload handed to the decoder
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
    logic            in_ds;
`ifdef FETCH_ADEL_EN
    logic            adel;
`endif
  } if_id_t;

  // Sequential PC step; wraps modulo 2^32
  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID register bank: bubble on reset/flush, hold on stall_d, otherwise load.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush, stall_d    bubble insert / hold controls
//   is_branch_d       instruction currently in ID is a branch/jump
//   instr_i, pc_i     fetched word and its PC
//   adel_i            fetch PC misaligned (FETCH_ADEL_EN only)
//   q_o               registered IF/ID payload
module fetch_stage_if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            stall_d,
  input  logic            is_branch_d,
`ifdef FETCH_ADEL_EN
  input  logic            adel_i,
`endif
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
  output if_id_t          q_o
);

  if_id_t q_d, q_q;

  // Next-state: flush inserts a bubble, stall holds, otherwise load F-stage data
  always_comb begin
    q_d = q_q;
    if (flush) begin
      q_d.instr    = NOP_INST;
      q_d.pc       = '0;
      q_d.pc_plus4 = PC_STEP;
      q_d.valid    = 1'b0;
      q_d.in_ds    = 1'b0;
`ifdef FETCH_ADEL_EN
      q_d.adel     = 1'b0;
`endif
    end else if (!stall_d) begin
      q_d.instr    = instr_i;
      q_d.pc       = pc_i;
      q_d.pc_plus4 = pc_inc(pc_i);
      q_d.valid    = 1'b1;
      // Only a real branch in ID makes the following word a delay slot
      q_d.in_ds    = is_branch_d & q_q.valid;
`ifdef FETCH_ADEL_EN
      q_d.adel     = adel_i;
      // Faulting fetch: keep the PC for EPC/BadVAddr but never decode the word
      if (adel_i) q_d.instr = NOP_INST;
`endif
    end
  end

  // Register with synchronous reset to the bubble state
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q.instr    <= NOP_INST;
      q_q.pc       <= '0;
      q_q.pc_plus4 <= PC_STEP;
      q_q.valid    <= 1'b0;
      q_q.in_ds    <= 1'b0;
`ifdef FETCH_ADEL_EN
      q_q.adel     <= 1'b0;
`endif
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register for the 5-stage MIPS core.
// Owns the PC, drives the synchronous instruction SRAM and feeds the decoder.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   stall_f, stall_d, flush, exc_pc  hazard / CP0 controls
//   branch_taken_d, branch_target_d  ID-stage redirect; is_branch_d marks a branch in ID
//   inst_sram_*                      SRAM interface (read-only; addr is combinational pc_next)
//   pc_f                             PC of the word on inst_sram_rdata this cycle
//   instr_d, pc_d, pc_plus4_d, valid_d, in_ds_d   IF/ID outputs
//   adel_d                           misaligned fetch flag (only with FETCH_ADEL_EN)
// Optional feature macro: FETCH_ADEL_EN.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_f,
  input  logic            stall_d,
  input  logic            flush,
  input  logic [XLEN-1:0] exc_pc,
  input  logic            branch_taken_d,
  input  logic [XLEN-1:0] branch_target_d,
  input  logic            is_branch_d,
  output logic            inst_sram_en,
  output logic [3:0]      inst_sram_wen,
  output logic [XLEN-1:0] inst_sram_addr,
  output logic [XLEN-1:0] inst_sram_wdata,
  input  logic [XLEN-1:0] inst_sram_rdata,
  output logic [XLEN-1:0] pc_f,
  output logic [XLEN-1:0] instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus4_d,
  output logic            valid_d,
  output logic            in_ds_d
`ifdef FETCH_ADEL_EN
  ,
  output logic            adel_d
`endif
);

  logic            hold_f;
  logic [XLEN-1:0] pc_f_d, pc_f_q;
  if_id_t          if_id;

  // A decode stall also freezes fetch so the held word is re-read
  assign hold_f = stall_f | stall_d;

  // PC mux: reset > flush > hold > branch > sequential
  always_comb begin
    pc_f_d = pc_inc(pc_f_q);
    if (rst)                 pc_f_d = RESET_PC;
    else if (flush)          pc_f_d = exc_pc;
    else if (hold_f)         pc_f_d = pc_f_q;
    else if (branch_taken_d) pc_f_d = branch_target_d;
  end

  always_ff @(posedge clk) begin
    if (rst) pc_f_q <= RESET_PC;
    else     pc_f_q <= pc_f_d;
  end

  assign inst_sram_en    = 1'b1;
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_wdata = '0;
`ifdef FETCH_ADEL_EN
  assign inst_sram_addr  = {pc_f_d[XLEN-1:2], 2'b00};
`else
  assign inst_sram_addr  = pc_f_d;
`endif

  fetch_stage_if_id_reg #(
    .NOP_INST (NOP_INST)
  ) u_if_id (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .stall_d     (stall_d),
    .is_branch_d (is_branch_d),
`ifdef FETCH_ADEL_EN
    .adel_i      (pc_f_q[1:0] != 2'b00),
`endif
    .instr_i     (inst_sram_rdata),
    .pc_i        (pc_f_q),
    .q_o         (if_id)
  );

  assign pc_f       = pc_f_q;
  assign instr_d    = if_id.instr;
  assign pc_d       = if_id.pc;
  assign pc_plus4_d = if_id.pc_plus4;
  assign valid_d    = if_id.valid;
  assign in_ds_d    = if_id.in_ds;
`ifdef FETCH_ADEL_EN
  assign adel_d     = if_id.adel;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, an optional
// misaligned-fetch sequence, and randomized cycles against a behavioural model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_f = 1'b0, stall_d = 1'b0, flush = 1'b0;
  logic [31:0] exc_pc = '0;
  logic        branch_taken_d = 1'b0;
  logic [31:0] branch_target_d = '0;
  logic        is_branch_d = 1'b0;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic [31:0] inst_sram_rdata = '0;
  logic [31:0] pc_f, instr_d, pc_d, pc_plus4_d;
  logic        valid_d, in_ds_d;
`ifdef FETCH_ADEL_EN
  logic        adel_d;
  localparam bit ADEL = 1'b1;
`else
  localparam bit ADEL = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  fetch_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall_f         (stall_f),
    .stall_d         (stall_d),
    .flush           (flush),
    .exc_pc          (exc_pc),
    .branch_taken_d  (branch_taken_d),
    .branch_target_d (branch_target_d),
    .is_branch_d     (is_branch_d),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .pc_f            (pc_f),
    .instr_d         (instr_d),
    .pc_d            (pc_d),
    .pc_plus4_d      (pc_plus4_d),
    .valid_d         (valid_d),
    .in_ds_d         (in_ds_d)
`ifdef FETCH_ADEL_EN
    ,
    .adel_d          (adel_d)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory contents as a pure function of the word address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h2401_0001;
    return a ^ 32'h1357_9BDF;
  endfunction

  // Synchronous SRAM: data appears one edge after the address
  always @(posedge clk) inst_sram_rdata <= mem_word(inst_sram_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: what the F stage holds and what ID currently sees
  logic [31:0] m_pc_f = '0, m_instr = '0, m_pc_d = '0;
  logic        m_valid = 1'b0, m_ins = 1'b0, m_adel = 1'b0;

  function automatic logic [31:0] model_next_pc();
    if (rst)                   return 32'hBFC0_0000;
    if (flush)                 return exc_pc;
    if (stall_f || stall_d)    return m_pc_f;
    if (branch_taken_d)        return branch_target_d;
    return m_pc_f + 32'd4;
  endfunction

  task automatic step(input logic r, input logic sf, input logic sd, input logic fl,
                      input logic [31:0] exc, input logic b, input logic [31:0] tg,
                      input logic ib);
    logic [31:0] nxt, exp_addr;
    logic        mis;
    rst = r; stall_f = sf; stall_d = sd; flush = fl; exc_pc = exc;
    branch_taken_d = b; branch_target_d = tg; is_branch_d = ib;
    @(negedge clk);
    nxt = model_next_pc();
    exp_addr = ADEL ? {nxt[31:2], 2'b00} : nxt;
    chk("sram_addr", inst_sram_addr, exp_addr);
    chk("sram_en_wen", {27'd0, inst_sram_en, inst_sram_wen}, 32'h10);
    chk("sram_wdata", inst_sram_wdata, 32'h0);
    @(posedge clk);
    // ID-side update uses the pre-edge model state
    if (r || fl) begin
      m_instr = 32'h0; m_pc_d = 32'h0; m_valid = 1'b0; m_ins = 1'b0; m_adel = 1'b0;
    end else if (!sd) begin
      mis     = ADEL && (m_pc_f[1:0] != 2'b00);
      m_instr = mis ? 32'h0 : mem_word(m_pc_f);
      m_pc_d  = m_pc_f;
      m_ins   = ib && m_valid;
      m_valid = 1'b1;
      m_adel  = mis;
    end
    m_pc_f = nxt;
    #1;
    chk("pc_f", pc_f, m_pc_f);
    chk("instr_d", instr_d, m_instr);
    chk("pc_d", pc_d, m_pc_d);
    chk("pc_plus4_d", pc_plus4_d, m_pc_d + 32'd4);
    chk("valid_d", {31'd0, valid_d}, {31'd0, m_valid});
    chk("in_ds_d", {31'd0, in_ds_d}, {31'd0, m_ins});
`ifdef FETCH_ADEL_EN
    chk("adel_d", {31'd0, adel_d}, {31'd0, m_adel});
`endif
  endtask

  typedef struct {
    logic        rst, sf, sd, fl;
    logic [31:0] exc;
    logic        bt;
    logic [31:0] tgt;
    logic        isb;
    logic [31:0] e_pc_f, e_instr, e_pc_d;
    logic        e_valid, e_ins;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic sf, input logic sd, input logic fl,
                              input logic [31:0] exc, input logic bt, input logic [31:0] tgt,
                              input logic isb, input logic [31:0] epcf, input logic [31:0] einstr,
                              input logic [31:0] epcd, input logic ev, input logic eins);
    vec_t v;
    v.rst = r; v.sf = sf; v.sd = sd; v.fl = fl; v.exc = exc; v.bt = bt; v.tgt = tgt;
    v.isb = isb; v.e_pc_f = epcf; v.e_instr = einstr; v.e_pc_d = epcd;
    v.e_valid = ev; v.e_ins = eins;
    return v;
  endfunction

  localparam int NV = 20;
  vec_t vecs[NV];

  initial begin
    // Directed sequence: reset, straight-line, branch + delay slot, stall, flush, wrap
    vecs[0]  = mk(1,0,0,0, 0,0,0,0, 32'hBFC0_0000, 32'h0, 32'h0, 0,0);
    vecs[1]  = vecs[0];
    vecs[2]  = vecs[0];
    vecs[3]  = mk(0,0,0,0, 0,0,0,0, 32'hBFC0_0004, 32'h2401_0001, 32'hBFC0_0000, 1,0);
    vecs[4]  = mk(0,0,0,0, 0,0,0,0, 32'hBFC0_0008, mem_word(32'hBFC0_0004), 32'hBFC0_0004, 1,0);
    vecs[5]  = mk(0,0,0,0, 0,0,0,0, 32'hBFC0_000C, mem_word(32'hBFC0_0008), 32'hBFC0_0008, 1,0);
    vecs[6]  = mk(0,0,0,0, 0,1,32'hBFC0_0100,1, 32'hBFC0_0100, mem_word(32'hBFC0_000C), 32'hBFC0_000C, 1,1);
    vecs[7]  = mk(0,0,0,0, 0,0,0,0, 32'hBFC0_0104, mem_word(32'hBFC0_0100), 32'hBFC0_0100, 1,0);
    vecs[8]  = mk(0,0,0,0, 0,0,0,0, 32'hBFC0_0108, mem_word(32'hBFC0_0104), 32'hBFC0_0104, 1,0);
    vecs[9]  = mk(0,1,1,0, 0,1,32'hBFC0_0200,1, 32'hBFC0_0108, mem_word(32'hBFC0_0104), 32'hBFC0_0104, 1,0);
    vecs[10] = vecs[9];
    vecs[11] = mk(0,0,0,0, 0,1,32'hBFC0_0200,1, 32'hBFC0_0200, mem_word(32'hBFC0_0108), 32'hBFC0_0108, 1,1);
    vecs[12] = mk(0,1,1,1, 32'hBFC0_0380,1,32'hBFC0_0400,1, 32'hBFC0_0380, 32'h0, 32'h0, 0,0);
    vecs[13] = mk(0,0,0,0, 0,0,0,0, 32'hBFC0_0384, mem_word(32'hBFC0_0380), 32'hBFC0_0380, 1,0);
    vecs[14] = mk(0,0,0,1, 32'hFFFF_FFFC,0,0,0, 32'hFFFF_FFFC, 32'h0, 32'h0, 0,0);
    vecs[15] = mk(0,0,0,0, 0,0,0,0, 32'h0000_0000, mem_word(32'hFFFF_FFFC), 32'hFFFF_FFFC, 1,0);
    vecs[16] = mk(0,0,0,0, 0,0,0,0, 32'h0000_0004, mem_word(32'h0000_0000), 32'h0000_0000, 1,0);
    vecs[17] = mk(0,0,1,0, 0,0,0,0, 32'h0000_0004, mem_word(32'h0000_0000), 32'h0000_0000, 1,0);
    vecs[18] = mk(1,1,0,0, 0,0,0,0, 32'hBFC0_0000, 32'h0, 32'h0, 0,0);
    vecs[19] = mk(0,0,0,0, 0,0,0,1, 32'hBFC0_0004, 32'h2401_0001, 32'hBFC0_0000, 1,0);

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].rst, vecs[i].sf, vecs[i].sd, vecs[i].fl, vecs[i].exc,
           vecs[i].bt, vecs[i].tgt, vecs[i].isb);
      chk($sformatf("vec%0d_pc_f", i), pc_f, vecs[i].e_pc_f);
      chk($sformatf("vec%0d_instr_d", i), instr_d, vecs[i].e_instr);
      chk($sformatf("vec%0d_pc_d", i), pc_d, vecs[i].e_pc_d);
      chk($sformatf("vec%0d_pc_plus4_d", i), pc_plus4_d, vecs[i].e_pc_d + 32'd4);
      chk($sformatf("vec%0d_valid_d", i), {31'd0, valid_d}, {31'd0, vecs[i].e_valid});
      chk($sformatf("vec%0d_in_ds_d", i), {31'd0, in_ds_d}, {31'd0, vecs[i].e_ins});
    end

`ifdef FETCH_ADEL_EN
    // Misaligned redirect: SRAM sees the aligned word, ID sees a faulting bubble-word
    branch_taken_d = 1'b1; branch_target_d = 32'hBFC0_0102; is_branch_d = 1'b1;
    rst = 1'b0; stall_f = 1'b0; stall_d = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("adel_sram_addr", inst_sram_addr, 32'hBFC0_0100);
    step(0,0,0,0, 0,1,32'hBFC0_0102,1);
    chk("adel_pc_f", pc_f, 32'hBFC0_0102);
    step(0,0,0,0, 0,0,0,0);
    chk("adel_flag", {31'd0, adel_d}, 32'd1);
    chk("adel_instr", instr_d, 32'h0);
    chk("adel_pc_d", pc_d, 32'hBFC0_0102);
    chk("adel_valid", {31'd0, valid_d}, 32'd1);
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      logic        r, sf, sd, fl, b, ib;
      logic [31:0] exc, tg;
      r   = ($urandom_range(0, 63) == 0);
      fl  = ($urandom_range(0, 15) == 0);
      sf  = ($urandom_range(0, 4) == 0);
      sd  = ($urandom_range(0, 5) == 0);
      b   = ($urandom_range(0, 3) == 0);
      ib  = b | ($urandom_range(0, 7) == 0);
      exc = $urandom();
      tg  = $urandom();
      if (!ADEL || $urandom_range(0, 3) != 0) begin
        exc[1:0] = 2'b00;
        tg[1:0]  = 2'b00;
      end
      step(r, sf, sd, fl, exc, b, tg, ib);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS core in the SRAM-interface SoC.
- Owns the PC and drives the synchronous instruction SRAM. Registers {instruction, PC, PC+4, valid, delay-slot flag} for the ID-stage decoder.
- Accepts stalls and exception flushes from the hazard/CP0 logic, and branch/jump redirects resolved in ID.

Parameters:
- RESET_PC, 32'hBFC0_0000, PC value fetched first after reset.
- NOP_INST, 32'h0000_0000, instruction word inserted into the IF/ID register on a bubble.

Ports:
- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-high
- stall_f  in  1  hold PC / re-fetch the same address
- stall_d  in  1  hold the IF/ID register
- flush  in  1  exception/eret redirect; kills the instruction being fetched
- exc_pc  in  32  redirect target when flush=1
- branch_taken_d  in  1  ID-stage branch/jump/jr taken
- branch_target_d  in  32  ID-stage redirect target
- is_branch_d  in  1  instruction now in ID is a branch or jump (any kind, taken or not)
- inst_sram_en  out  1  SRAM read enable
- inst_sram_wen  out  4  always 4'b0000
- inst_sram_addr  out  32  fetch address (= pc_next)
- inst_sram_wdata  out  32  always 0
- inst_sram_rdata  in  32  read data, valid one cycle after address
- pc_f  out  32  PC of the instruction whose data is on inst_sram_rdata this cycle
- instr_d  out  32  instruction to decoder
- pc_d  out  32  PC of instr_d
- pc_plus4_d  out  32  pc_d+4
- valid_d  out  1  instr_d is a real instruction (0 = bubble)
- in_ds_d  out  1  instr_d occupies a branch delay slot
- adel_d  out  1  fetch address misaligned (present only with FETCH_ADEL_EN)

Behaviour:
- Internal hold_f = stall_f | stall_d; stall_d without stall_f is treated as both.
- pc_next priority:
  - rst: RESET_PC
  - flush: exc_pc
  - hold_f: pc_f
  - branch_taken_d: branch_target_d
  - otherwise: pc_f+4 (mod 2^32; wraps at 32'hFFFF_FFFC)
- While hold_f, a redirect is ignored; ID still holds the branch and re-asserts it next cycle.
- pc_f <= pc_next every cycle. inst_sram_addr = pc_next combinationally. inst_sram_en = 1 always, including during rst.
- Result: on the first cycle after reset, pc_f = RESET_PC and rdata = mem[RESET_PC]. A held PC re-reads the same word, so no skid buffer is needed.
- Delay slot: not flushed by a branch. The instruction at branch_pc+4 is already in F when the branch is in ID and proceeds normally. The redirect target is fetched next.
- IF/ID register update:
  - rst or flush: instr_d=NOP_INST, pc_d=0, pc_plus4_d=4, valid_d=0, in_ds_d=0, adel_d=0.
  - Else if stall_d: all outputs hold.
  - Else: instr_d <= rdata, pc_d <= pc_f, pc_plus4_d <= pc_f+4, valid_d <= 1, in_ds_d <= is_branch_d & valid_d.
- Simultaneous flush and stall: flush wins in both PC and IF/ID.
- Simultaneous flush and branch_taken_d: exc_pc wins.
- Reset mid-operation: all state returns to reset values on the next edge; no partial update.
- Latency: address to IF/ID output is 2 edges.

Optional Feature:
- Macro FETCH_ADEL_EN.
- Defined:
  - The IF/ID load sets adel_d <= (pc_f[1:0] != 0).
  - When misaligned, instr_d <= NOP_INST while pc_d still holds the faulting PC, for CP0 BadVAddr/EPC.
  - inst_sram_addr has bits [1:0] forced to 0.
- Undefined: the adel_d port is absent, and the PC is used unchecked.

Decomposition:
- defines.vh gains RESET_PC and the NOP encoding.
- Natural sub-module if_id_reg: the flush/stall/load register bank.
- PC mux and PC register stay in fetch_stage.

Test Plan:
- Reset held 3 cycles, then released with mem[BFC00000]=0x24010001 → pc_f=BFC00000 in cycle 1. Cycle 2: instr_d=0x24010001, pc_d=BFC00000, valid_d=1, in_ds_d=0.
- Sequential run of 4 instructions → pc_d steps BFC00000, 04, 08, 0C. pc_plus4_d=pc_d+4.
- is_branch_d=1 and branch_taken_d=1 (target BFC00100) while the branch at BFC00008 is in ID → next instr_d is from BFC0000C with in_ds_d=1, then from BFC00100 with in_ds_d=0.
- stall_f=stall_d=1 for 2 cycles with a branch in ID → inst_sram_addr, pc_f and IF/ID outputs are all constant. The redirect takes effect only on the first unstalled cycle.
- flush=1, exc_pc=BFC00380, simultaneous with stall and branch_taken_d → next cycle pc_f=BFC00380, valid_d=0, instr_d=0. The next load has pc_d=BFC00380.
- With FETCH_ADEL_EN, redirect to BFC00102 → adel_d=1, instr_d=0, pc_d=BFC00102, inst_sram_addr=BFC00100.
